// File: rtl/ln_sum_pkg.sv
// Shared constants, FSM state encoding and the ln(1+x) segment table for the
// softmax stage-3 log unit.
package ln_sum_pkg;

    localparam int DW    = 32;
    localparam int FRAC  = 10;
    localparam int LN2_Q = 710;

    typedef enum logic [2:0] {
        ST_ACC = 3'd0,
        ST_S1  = 3'd1,
        ST_S2  = 3'd2,
        ST_S3  = 3'd3,
        ST_OUT = 3'd4
    } state_e;

    // L[i] = round(1024 * ln(1 + i/16)), i = 0..16; L[16] equals LN2_Q.
    function automatic logic [9:0] ln_tab(input logic [4:0] idx);
        logic [9:0] v;
        case (idx)
            5'd0:    v = 10'd0;
            5'd1:    v = 10'd62;
            5'd2:    v = 10'd121;
            5'd3:    v = 10'd176;
            5'd4:    v = 10'd228;
            5'd5:    v = 10'd278;
            5'd6:    v = 10'd326;
            5'd7:    v = 10'd372;
            5'd8:    v = 10'd415;
            5'd9:    v = 10'd457;
            5'd10:   v = 10'd497;
            5'd11:   v = 10'd536;
            5'd12:   v = 10'd573;
            5'd13:   v = 10'd609;
            5'd14:   v = 10'd644;
            5'd15:   v = 10'd677;
            5'd16:   v = 10'd710;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ln_lut.sv
// Piecewise-linear ln(1+m/1024) in Q.10: 16 segments selected by seg_i,
// interpolated by the 6-bit in-segment fraction fr_i.
module ln_lut
    import ln_sum_pkg::*;
(
    input  logic [3:0] seg_i,
    input  logic [5:0] fr_i,
    output logic [9:0] lut_o
);

    logic [9:0]  lo;
    logic [9:0]  hi;
    logic [6:0]  diff;
    logic [12:0] prod;

    assign lo = ln_tab({1'b0, seg_i});
    assign hi = ln_tab({1'b0, seg_i} + 5'd1);

    // Adjacent entries differ by less than 64, so the slope fits in 7 bits.
    assign diff  = 7'(hi - lo);
    assign prod  = {6'b0, diff} * {7'b0, fr_i};
    assign lut_o = lo + {3'b0, prod[12:6]};

endmodule

// File: rtl/ln_sum.sv
// Softmax stage 3: accumulates exp values of a row into F, then produces
// lnF in signed 22.10 through a three-stage normalise / lookup pipeline.
module ln_sum
    import ln_sum_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] ln_out,
    output logic          sum_zero,
    output logic [2:0]    dbg_state
);

    // Handshake: a beat transfers on any edge where valid and ready are both
    // high; a producer holds its data while ready is low, and out_valid stays
    // high with ln_out/sum_zero frozen until the consumer raises out_ready.

    localparam logic [DW-1:0] LN_ZERO = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] LN2_W   = DW'(LN2_Q);

    state_e          state_q;
    logic [DW-1:0]   acc_q;
    logic [4:0]      p_q;
    logic            zero_q;
    logic [3:0]      seg_q;
    logic [5:0]      fr_q;
    logic [5:0]      w_q;
    logic [DW-1:0]   ln_q;
    logic            sum_zero_q;
    logic            out_valid_q;

    logic [DW:0]      acc_sum;
    logic [DW-1:0]    acc_d;
    logic [4:0]       lod_p;
    logic             lod_zero;
    logic [DW+FRAC-1:0] norm;
    logic [9:0]       mant;
    logic [5:0]       w_d;
    logic [9:0]       lut;
    logic [DW-1:0]    w_ext;
    logic [DW-1:0]    res_d;

    assign acc_sum = {1'b0, acc_q} + {1'b0, in_data};
    assign acc_d   = acc_sum[DW] ? {DW{1'b1}} : acc_sum[DW-1:0];

    always_comb begin
        lod_p    = 5'd0;
        lod_zero = (acc_q == '0);
        for (int i = 0; i < DW; i++) begin
            if (acc_q[i]) lod_p = 5'(i);
        end
    end

    // Shift the leading one to bit FRAC; the ten bits below it form m,
    // with zeros filling in when p < FRAC.
    assign norm = {acc_q, {FRAC{1'b0}}} >> p_q;
    assign mant = norm[9:0];
    assign w_d  = {1'b0, p_q} - 6'(FRAC);

    ln_lut u_ln_lut (
        .seg_i (seg_q),
        .fr_i  (fr_q),
        .lut_o (lut)
    );

    // The low DW bits of a product are identical for signed and unsigned
    // operands, so sign-extending w is enough to get w*LN2_Q right.
    assign w_ext = {{(DW-6){w_q[5]}}, w_q};
    assign res_d = w_ext * LN2_W + {{(DW-10){1'b0}}, lut};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            p_q         <= '0;
            zero_q      <= 1'b0;
            seg_q       <= '0;
            fr_q        <= '0;
            w_q         <= '0;
            ln_q        <= '0;
            sum_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        if (in_last) state_q <= ST_S1;
                    end
                end
                ST_S1: begin
                    p_q     <= lod_p;
                    zero_q  <= lod_zero;
                    state_q <= ST_S2;
                end
                ST_S2: begin
                    seg_q   <= mant[9:6];
                    fr_q    <= mant[5:0];
                    w_q     <= w_d;
                    state_q <= ST_S3;
                end
                ST_S3: begin
                    if (zero_q) begin
                        ln_q       <= LN_ZERO;
                        sum_zero_q <= 1'b1;
                    end else begin
                        ln_q <= res_d;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        sum_zero_q  <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign ln_out    = ln_q;
    assign sum_zero  = sum_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ln_sum.sv
// Self-checking bench for ln_sum: directed rows, backpressure, saturation,
// mid-calculation reset and randomized rows against an arithmetic model.
module tb_ln_sum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ln_out;
    logic        sum_zero;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int ltab[17];
    logic [31:0] row_q[$];

    ln_sum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ln_out    (ln_out),
        .sum_zero  (sum_zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint model_sum(input longint a, input longint b);
        longint s;
        s = a + b;
        return (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
    endfunction

    // lnF in Q.10: F = 2^(p-10) * (1 + m/1024), ln = (p-10)*ln2 + ln(1+m/1024).
    function automatic logic [31:0] model_ln(input longint f);
        int     p;
        longint m;
        int     seg;
        int     fr;
        int     lut;
        int     r;
        if (f == 0) return 32'h8000_0000;
        p = 0;
        while ((f >> (p + 1)) != 0) p++;
        m   = ((f * 1024) / (64'd1 << p)) - 1024;
        seg = int'(m / 64);
        fr  = int'(m % 64);
        lut = ltab[seg] + ((ltab[seg+1] - ltab[seg]) * fr) / 64;
        r   = (p - 10) * 710 + lut;
        return 32'(r);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic drive_row(input logic gaps, output int lat,
                             output logic [31:0] got_ln, output logic got_zero);
        int n;
        n = row_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(0, 1));
                    in_data  = $urandom;
                    @(posedge clk); #1;
                end
                in_last = 1'b0;
            end
            send_beat(row_q[i], (i == n - 1));
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got_ln   = ln_out;
        got_zero = sum_zero;
    endtask

    task automatic finish_row();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        n_vec++;
        if (ln_out !== 32'h0) begin
            n_err++; $display("FAIL reset_ln_out got=%h want=0", ln_out);
        end
        n_vec++;
        if (sum_zero !== 1'b0) begin
            n_err++; $display("FAIL reset_sum_zero got=%0b want=0", sum_zero);
        end
        n_vec++;
        if (dbg_state !== 3'd0) begin
            n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state);
        end
    endtask

    task automatic test_directed();
        logic [31:0] b0[6];
        logic [31:0] b1[6];
        int          nb[6];
        logic [31:0] exp_ln[6];
        logic        exp_z[6];
        int          lat;
        logic [31:0] got_ln;
        logic        got_z;
        b0 = '{1024, 1024, 1024, 2048, 0, 0};
        b1 = '{0,    1024, 512,  1024, 0, 0};
        nb = '{1, 2, 2, 2, 1, 2};
        exp_ln = '{32'd0, 32'd710, 32'd415, 32'd1125, 32'h8000_0000, 32'h8000_0000};
        exp_z  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            row_q.delete();
            row_q.push_back(b0[c]);
            if (nb[c] == 2) row_q.push_back(b1[c]);
            drive_row(1'b0, lat, got_ln, got_z);
            n_vec++;
            if (lat != 3) begin
                n_err++; $display("FAIL dir%0d_latency got=%0d want=3", c, lat);
            end
            n_vec++;
            if (got_ln !== exp_ln[c]) begin
                n_err++; $display("FAIL dir%0d_ln_out got=%0d want=%0d", c, got_ln, exp_ln[c]);
            end
            n_vec++;
            if (got_z !== exp_z[c]) begin
                n_err++; $display("FAIL dir%0d_sum_zero got=%0b want=%0b", c, got_z, exp_z[c]);
            end
            finish_row();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_release got v=%0b r=%0b want v=0 r=1", c, out_valid, in_ready);
            end
            n_vec++;
            if (ln_out !== exp_ln[c] || sum_zero !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_after_hs got ln=%h z=%0b want ln=%h z=0", c, ln_out, sum_zero, exp_ln[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] got_ln;
        logic        got_z;
        row_q.delete();
        row_q.push_back(32'd1024);
        row_q.push_back(32'd1024);
        drive_row(1'b0, lat, got_ln, got_z);
        n_vec++;
        if (got_ln !== 32'd710) begin
            n_err++; $display("FAIL bp_ln_out got=%0d want=710", got_ln);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = 32'd5000;
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || ln_out !== 32'd710 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%0b ln=%0d r=%0b want v=1 ln=710 r=0", k, out_valid, ln_out, in_ready);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        finish_row();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release got r=%0b v=%0b want r=1 v=0", in_ready, out_valid);
        end
        row_q.delete();
        row_q.push_back(32'd1024);
        drive_row(1'b0, lat, got_ln, got_z);
        n_vec++;
        if (got_ln !== 32'd0 || got_z !== 1'b0 || lat != 3) begin
            n_err++; $display("FAIL bp_next_row got ln=%0d z=%0b lat=%0d want ln=0 z=0 lat=3", got_ln, got_z, lat);
        end
        finish_row();
    endtask

    task automatic test_saturation();
        int          lat;
        logic [31:0] got_ln;
        logic        got_z;
        row_q.delete();
        row_q.push_back(32'hFFFF_FFFF);
        row_q.push_back(32'hFFFF_FFFF);
        drive_row(1'b0, lat, got_ln, got_z);
        // 21*710 + (677 + (33*63)>>6) = 14910 + 709
        n_vec++;
        if (got_ln !== 32'd15619 || got_z !== 1'b0) begin
            n_err++; $display("FAIL sat_ln_out got ln=%0d z=%0b want ln=15619 z=0", got_ln, got_z);
        end
        finish_row();
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] got_ln;
        logic        got_z;
        send_beat(32'd1024, 1'b0);
        send_beat(32'd1024, 1'b1);
        @(posedge clk); #1;
        n_vec++;
        if (dbg_state !== 3'd2) begin
            n_err++; $display("FAIL rstmid_in_s2 got=%0d want=2", dbg_state);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ln_out !== 32'h0 || sum_zero !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_outputs got r=%0b v=%0b ln=%h z=%0b want r=1 v=0 ln=0 z=0", in_ready, out_valid, ln_out, sum_zero);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        row_q.delete();
        row_q.push_back(32'd1024);
        drive_row(1'b0, lat, got_ln, got_z);
        n_vec++;
        if (got_ln !== 32'd0 || got_z !== 1'b0 || lat != 3) begin
            n_err++; $display("FAIL rstmid_fresh_row got ln=%0d z=%0b lat=%0d want ln=0 z=0 lat=3", got_ln, got_z, lat);
        end
        finish_row();
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] got_ln;
        logic        got_z;
        logic [31:0] exp_ln;
        logic        exp_z;
        longint      f;
        for (int r = 0; r < 40; r++) begin
            int len;
            int hold;
            len = $urandom_range(1, 5);
            row_q.delete();
            f = 0;
            for (int i = 0; i < len; i++) begin
                logic [31:0] d;
                case ($urandom_range(0, 3))
                    0:       d = $urandom_range(0, 2047);
                    1:       d = $urandom_range(0, 1 << 20);
                    2:       d = $urandom;
                    default: d = 32'd0;
                endcase
                row_q.push_back(d);
                f = model_sum(f, longint'(d));
            end
            exp_ln = model_ln(f);
            exp_z  = (f == 0);
            drive_row(1'b1, lat, got_ln, got_z);
            n_vec++;
            if (lat != 3) begin
                n_err++; $display("FAIL rnd%0d_latency got=%0d want=3", r, lat);
            end
            n_vec++;
            if (got_ln !== exp_ln || got_z !== exp_z) begin
                n_err++;
                $display("FAIL rnd%0d_result F=%0d got ln=%0d z=%0b want ln=%0d z=%0b", r, f, $signed(got_ln), got_z, $signed(exp_ln), exp_z);
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                n_vec++;
                if (out_valid !== 1'b1 || ln_out !== exp_ln) begin
                    n_err++; $display("FAIL rnd%0d_hold got v=%0b ln=%0d want v=1 ln=%0d", r, out_valid, ln_out, exp_ln);
                end
            end
            finish_row();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 17; i++) ltab[i] = int'($floor(1024.0 * $ln(1.0 + i / 16.0) + 0.5));
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
